// File: rtl/inst_encoder_if.sv
// Request/response bundle for the instruction encoder.
// Request side: valid/ready, format tag, fields, 64-bit immediate.
// Response side: valid/ready FIFO head plus the saturating error counter.
interface inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [63:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [15:0] err_cnt;

   // Producer/consumer view (drives requests, accepts responses)
   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err, err_cnt
   );

   // Encoder view
   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err, err_cnt
   );
endinterface

// File: rtl/inst_encoder.sv
// RV64 instruction encoder: range/alignment-checks an immediate and packs a 32-bit word into an output FIFO.
// Latency: one cycle from request acceptance to out_valid when the FIFO is empty.
// Backpressure: in_ready = !full, independent of out_ready; head entry held stable while stalled.
module inst_encoder #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_encoder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] FMT_R  = 3'd0;
   localparam logic [2:0] FMT_I  = 3'd1;
   localparam logic [2:0] FMT_S  = 3'd2;
   localparam logic [2:0] FMT_SB = 3'd3;
   localparam logic [2:0] FMT_U  = 3'd4;
   localparam logic [2:0] FMT_UJ = 3'd5;

   // addi x0,x0,0 -- substituted for any request that fails the check
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic        err;
      logic [31:0] inst;
   } entry_t;

   // ------------------------------------------------------------------
   // Combinational encode
   // ------------------------------------------------------------------
   logic signed [63:0] imm_s;
   logic [63:0]        imm;
   logic [31:0]        packed_w;
   logic               legal;
   logic               in_12s;     // -2048 .. 2047
   logic               in_13s;     // -4096 .. 4094 (evenness checked separately)
   logic               in_21s;     // -1048576 .. 1048574
   logic               sext32;     // imm[63:31] all equal
   entry_t             wr_entry;

   assign imm    = bus.in_imm;
   assign imm_s  = signed'(bus.in_imm);
   assign in_12s = (imm_s >= -64'sd2048)    && (imm_s <= 64'sd2047);
   assign in_13s = (imm_s >= -64'sd4096)    && (imm_s <= 64'sd4094);
   assign in_21s = (imm_s >= -64'sd1048576) && (imm_s <= 64'sd1048574);
   assign sext32 = (&imm[63:31]) | ~(|imm[63:31]);

   // Pack the fields for the requested format and decide legality
   always_comb begin
      packed_w = '0;
      legal    = 1'b0;
      case (bus.in_fmt)
         FMT_R: begin
            packed_w = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
            legal    = 1'b1;
         end
         FMT_I: begin
            packed_w = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            legal    = in_12s;
         end
         FMT_S: begin
            packed_w = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:0], bus.in_opcode};
            legal    = in_12s;
         end
         FMT_SB: begin
            packed_w = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], bus.in_opcode};
            legal    = in_13s && !imm[0];
         end
         FMT_U: begin
            packed_w = {imm[31:12], bus.in_rd, bus.in_opcode};
            legal    = (imm[11:0] == 12'h000) && sext32;
         end
         FMT_UJ: begin
            packed_w = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            legal    = in_21s && !imm[0];
         end
         default: begin
            packed_w = '0;
            legal    = 1'b0;
         end
      endcase
   end

   // Illegal requests become a NOP tagged with err
   always_comb begin
      wr_entry.err  = !legal;
      wr_entry.inst = legal ? packed_w : NOP_INST;
   end

   // ------------------------------------------------------------------
   // Output FIFO: pointers carry one extra wrap bit to tell full from empty
   // ------------------------------------------------------------------
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   entry_t      mem_q [DEPTH];
   entry_t      head;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [15:0] err_cnt_q, err_cnt_d;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = bus.in_valid && !full;
   assign pop   = !empty && bus.out_ready;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_inst  = head.inst;
   assign bus.out_err   = head.err;
   assign bus.err_cnt   = err_cnt_q;

   // Next-state pointers and error count
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_cnt_d = err_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (wr_entry.err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer and counter registers; reset discards any buffered entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Entry storage; cleared on reset so the idle head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
      end
   end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV64 instruction encoder, the inverse of the decode-side immediate generator. Accepts a format tag, register and function fields, and a 64-bit signed immediate. Range- and alignment-checks the immediate, packs a 32-bit instruction word, and buffers it in a small output FIFO behind a valid/ready handshake. Used by the self-test and trace-replay path to build instruction streams in hardware.

## Interface
- `DEPTH`, 2: output FIFO depth in entries; power of 2, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_fmt`  in  3  format: 0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6 and 7 are illegal.
- `in_opcode`  in  7  opcode, written verbatim into bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields.
- `in_funct3`  in  3; `in_funct7`  in  7  function fields.
- `in_imm`  in  64  signed immediate; byte offset for SB and UJ; full value (low 12 bits zero) for U.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_inst`  out  32  encoded word at the FIFO head.
- `out_err`  out  1  head entry failed the range or format check.
- `err_cnt`  out  16  saturating count of accepted requests that failed the check.

## Operation
- Packing (`imm` = `in_imm`):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `in_imm` ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Legality checks, each evaluated on the full 64-bit signed value:
  - I and S: −2048 ≤ imm ≤ 2047.
  - SB: −4096 ≤ imm ≤ 4094 and imm[0] = 0.
  - U: imm[11:0] = 0 and imm[63:31] all equal (sign-extended 32-bit value).
  - UJ: −1048576 ≤ imm ≤ 1048574 and imm[0] = 0.
  - R: always legal.
  - Format 6 or 7: always illegal.
- Illegal request:
  - entry stored with inst = 32'h00000013 (`addi x0,x0,0`) and err = 1;
  - `err_cnt` increments, saturating at 16'hFFFF.
- Legal request: entry stored with the packed word and err = 0.
- Encoding is combinational from the inputs into the FIFO write port. There is no state machine beyond the FIFO pointers and the counter.
- FIFO:
  - write on `in_valid & in_ready`; read on `out_valid & out_ready`;
  - strict in-order delivery;
  - pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH;
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- `in_ready` = !full; it has no combinational dependence on `out_ready`.
- `out_valid` = !empty. `out_inst` and `out_err` come from the registered head entry and are stable while `out_valid & !out_ready`.

## Timing
- Reset (async assert, sync to `clk` on release):
  - pointers cleared; `out_valid`=0, `in_ready`=1;
  - `out_inst`=0, `out_err`=0, `err_cnt`=0.
  - Reset asserted mid-stream discards all buffered entries. No output is produced until new requests are accepted.
- Latency: a request accepted at edge N is visible at `out_valid` after edge N (one cycle) when the FIFO was empty.
- Throughput: one request per cycle in steady state when `out_ready`=1 (DEPTH ≥ 2).
- Simultaneous push and pop when not full and not empty: occupancy is unchanged.
- Simultaneous push and pop with the FIFO empty: push only; the pop is impossible because `out_valid`=0.
- When full: `in_ready`=0 regardless of `out_ready`. After a pop at edge N, `in_ready`=1 in the cycle following edge N.
- `err_cnt` updates on the same edge as the push of the illegal entry.

## Test plan
- I-type: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → `out_inst`=0x00500093, `out_err`=0, one cycle after acceptance.
- SB and U:
  - fmt=3, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=−8 → 0xFE208CE3;
  - fmt=4, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- UJ: fmt=5, opcode=0x6F, rd=1, imm=2048 → 0x001000EF; then imm=−2 → 0xFFFFF0EF.
- Errors:
  - I-type imm=2048 → 0x00000013 with `out_err`=1;
  - SB imm=3 → 0x00000013 with `out_err`=1;
  - fmt=7 → 0x00000013 with `out_err`=1;
  - `err_cnt` reads 3 after these three requests.
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back requests → exactly 2 accepted and `in_ready`=0; raise `out_ready` → outputs appear in order, the 3rd request is accepted, and no entry is lost or duplicated.
- Reset mid-stream: 2 entries buffered and `err_cnt`=1; assert `rst_n`=0 asynchronously → `out_valid`=0, `err_cnt`=0 and `in_ready`=1 immediately; after release, the next request encodes correctly.
